mem_responder: RTL and testbench

//   Memory-side responder for the core's instruction and data ports: inst_addr/inst_ena,
//   mem_raddr/mem_rena, mem_waddr/mem_wdata/mem_wmask/mem_wena.

---
 rtl/mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: unified RAM, CLINT-style timer and a FIFO-backed UART TX register.
// Both read ports are combinational; stores, timer and FIFO state update on the clock edge.
module mem_responder #(
  parameter logic [63:0] RAM_BASE   = 64'h8000_0000,
  parameter int          RAM_WORDS  = 65536,
  parameter logic [63:0] CLINT_BASE = 64'h0200_0000,
  parameter logic [63:0] UART_BASE  = 64'h1000_0000,
  parameter int          UART_DEPTH = 8,
  parameter int          MTIME_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] inst_addr,
  input  logic        inst_ena,
  output logic [63:0] inst_rdata,
  input  logic [63:0] mem_raddr,
  input  logic        mem_rena,
  output logic [63:0] mem_rdata,
  input  logic [63:0] mem_waddr,
  input  logic [63:0] mem_wdata,
  input  logic [63:0] mem_wmask,
  input  logic        mem_wena,
  output logic        timer_irq,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  output logic        uart_overflow
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(UART_DEPTH);
  localparam int PRE_W   = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;

  localparam logic [63:0]      RAM_END       = RAM_BASE + 64'(RAM_WORDS) * 64'd8;
  localparam logic [63:0]      MTIMECMP_ADDR = CLINT_BASE + 64'h4000;
  localparam logic [63:0]      MTIME_ADDR    = CLINT_BASE + 64'hBFF8;
  localparam logic [PRE_W-1:0] PRE_LAST      = PRE_W'(MTIME_DIV - 1);
  localparam logic [FIFO_AW:0] FIFO_FULL     = (FIFO_AW + 1)'(UART_DEPTH);

  function automatic logic isRam(input logic [63:0] a);
    return (a >= RAM_BASE) && (a < RAM_END);
  endfunction

  function automatic logic [RAM_AW-1:0] ramIdx(input logic [63:0] a);
    return RAM_AW'((a - RAM_BASE) >> 3);
  endfunction

  logic [63:0]        r_ram [0:RAM_WORDS-1];
  logic [63:0]        r_mtime;
  logic [63:0]        r_mtimecmp;
  logic [PRE_W-1:0]   r_presc;
  logic               r_irq;
  logic [7:0]         r_fifo [0:UART_DEPTH-1];
  logic [FIFO_AW-1:0] r_wrPtr;
  logic [FIFO_AW-1:0] r_rdPtr;
  logic [FIFO_AW:0]   r_count;
  logic               r_overflow;

  logic [63:0] w_instWord;
  logic [63:0] w_readWord;
  logic [63:0] w_writeWord;
  logic        w_wRam;
  logic        w_wMtime;
  logic        w_wMtimecmp;
  logic        w_wUart;
  logic        w_tick;
  logic [63:0] w_mtimeInc;
  logic [63:0] w_mtimeNext;
  logic [63:0] w_mtimecmpNext;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_pushReq;
  logic        w_push;

  assign w_instWord  = inst_addr & ~64'h7;
  assign w_readWord  = mem_raddr & ~64'h7;
  assign w_writeWord = mem_waddr & ~64'h7;

  assign w_wRam      = mem_wena && isRam(w_writeWord);
  assign w_wMtime    = mem_wena && (w_writeWord == MTIME_ADDR);
  assign w_wMtimecmp = mem_wena && (w_writeWord == MTIMECMP_ADDR);
  assign w_wUart     = mem_wena && (w_writeWord == UART_BASE);

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FIFO_FULL);
  assign w_pop     = !w_empty && uart_tx_ready;
  assign w_pushReq = w_wUart && mem_wmask[0];
  // A push on a full FIFO still lands if the head leaves in the same cycle.
  assign w_push    = w_pushReq && (!w_full || w_pop);

  always_comb begin
    inst_rdata = '0;
    if (inst_ena && isRam(w_instWord)) begin
      inst_rdata = r_ram[ramIdx(w_instWord)];
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_rena) begin
      if (isRam(w_readWord)) begin
        mem_rdata = r_ram[ramIdx(w_readWord)];
      end else if (w_readWord == MTIMECMP_ADDR) begin
        mem_rdata = r_mtimecmp;
      end else if (w_readWord == MTIME_ADDR) begin
        mem_rdata = r_mtime;
      end else if (w_readWord == UART_BASE) begin
        mem_rdata[47:40] = {1'b0, w_empty, ~w_full, 5'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wRam) begin
      r_ram[ramIdx(w_writeWord)] <= (r_ram[ramIdx(w_writeWord)] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  // A store to mtime overrides only its masked bytes; the rest still take the increment.
  assign w_tick         = (r_presc == PRE_LAST);
  assign w_mtimeInc     = r_mtime + {63'b0, w_tick};
  assign w_mtimeNext    = w_wMtime ? ((w_mtimeInc & ~mem_wmask) | (mem_wdata & mem_wmask)) : w_mtimeInc;
  assign w_mtimecmpNext = w_wMtimecmp ? ((r_mtimecmp & ~mem_wmask) | (mem_wdata & mem_wmask)) : r_mtimecmp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc    <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_irq      <= 1'b0;
    end else begin
      r_presc    <= w_tick ? '0 : r_presc + 1'b1;
      r_mtime    <= w_mtimeNext;
      r_mtimecmp <= w_mtimecmpNext;
      r_irq      <= (r_mtime >= r_mtimecmp);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wrPtr] <= mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_pushReq && !w_push) r_overflow <= 1'b1;
    end
  end

  assign timer_irq     = r_irq;
  assign uart_tx_valid = !w_empty;
  assign uart_tx_data  = w_empty ? 8'h00 : r_fifo[r_rdPtr];
  assign uart_overflow = r_overflow;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue/array model of the memory map.
module tb_mem_responder;

  localparam logic [63:0] RAM_BASE   = 64'h8000_0000;
  localparam int          RAM_WORDS  = 65536;
  localparam logic [63:0] CLINT_BASE = 64'h0200_0000;
  localparam logic [63:0] UART_BASE  = 64'h1000_0000;
  localparam int          DEPTH      = 8;
  localparam int          DIV        = 1;
  localparam logic [63:0] CMP_A      = CLINT_BASE + 64'h4000;
  localparam logic [63:0] MTIME_A    = CLINT_BASE + 64'hBFF8;
  localparam logic [63:0] RAM_END    = RAM_BASE + 64'(RAM_WORDS) * 64'd8;
  localparam logic [63:0] RAM_LAST   = RAM_END - 64'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] inst_addr, mem_raddr, mem_waddr, mem_wdata, mem_wmask;
  logic        inst_ena, mem_rena, mem_wena, uart_tx_ready;
  logic [63:0] inst_rdata, mem_rdata;
  logic        timer_irq, uart_tx_valid, uart_overflow;
  logic [7:0]  uart_tx_data;

  always #5 clk = ~clk;

  mem_responder #(
    .RAM_BASE(RAM_BASE), .RAM_WORDS(RAM_WORDS), .CLINT_BASE(CLINT_BASE),
    .UART_BASE(UART_BASE), .UART_DEPTH(DEPTH), .MTIME_DIV(DIV)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_ena(inst_ena), .inst_rdata(inst_rdata),
    .mem_raddr(mem_raddr), .mem_rena(mem_rena), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_wena(mem_wena),
    .timer_irq(timer_irq),
    .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready),
    .uart_overflow(uart_overflow)
  );

  int total = 0;
  int bad = 0;
  bit chkEn = 1'b0;

  logic [63:0] mRam [int];
  logic [63:0] mMtime, mCmp;
  int          mPresc;
  logic        mIrq, mOvf;
  logic [7:0]  mFifo [$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] modelRead(input logic [63:0] addr, input logic en, input bit isInst);
    logic [63:0] w;
    int idx;
    w = addr & ~64'h7;
    if (!en) return 64'h0;
    if (w >= RAM_BASE && w < RAM_END) begin
      idx = int'((w - RAM_BASE) >> 3);
      return mRam.exists(idx) ? mRam[idx] : 64'hx;
    end
    if (isInst) return 64'h0;
    if (w == CMP_A) return mCmp;
    if (w == MTIME_A) return mMtime;
    if (w == UART_BASE)
      return {16'h0, 1'b0, mFifo.size() == 0, mFifo.size() != DEPTH, 5'b0, 40'h0};
    return 64'h0;
  endfunction

  // Advances the model by one clock using the inputs currently applied.
  task automatic modelUpdate();
    logic [63:0] w, inc;
    logic        newIrq, full, pop;
    int          idx;
    w = mem_waddr & ~64'h7;
    if (mem_wena && w >= RAM_BASE && w < RAM_END) begin
      idx = int'((w - RAM_BASE) >> 3);
      mRam[idx] = (mRam[idx] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
    if (rst) begin
      mMtime = 0; mCmp = '1; mPresc = 0; mIrq = 0; mOvf = 0;
      mFifo.delete();
    end else begin
      newIrq = (mMtime >= mCmp);
      inc = mMtime;
      if (mPresc == DIV - 1) begin
        inc = mMtime + 1;
        mPresc = 0;
      end else begin
        mPresc++;
      end
      mMtime = inc;
      if (mem_wena && w == MTIME_A) mMtime = (inc & ~mem_wmask) | (mem_wdata & mem_wmask);
      if (mem_wena && w == CMP_A) mCmp = (mCmp & ~mem_wmask) | (mem_wdata & mem_wmask);
      full = (mFifo.size() == DEPTH);
      pop = (mFifo.size() > 0) && uart_tx_ready;
      if (pop) void'(mFifo.pop_front());
      if (mem_wena && w == UART_BASE && mem_wmask[0]) begin
        if (!full || pop) mFifo.push_back(mem_wdata[7:0]);
        else mOvf = 1;
      end
      mIrq = newIrq;
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("inst_rdata", inst_rdata, modelRead(inst_addr, inst_ena, 1'b1));
      checkOutput("mem_rdata", mem_rdata, modelRead(mem_raddr, mem_rena, 1'b0));
      checkOutput("uart_tx_valid", 64'(uart_tx_valid), 64'(mFifo.size() > 0));
      checkOutput("uart_tx_data", 64'(uart_tx_data), (mFifo.size() > 0) ? 64'(mFifo[0]) : 64'h0);
      checkOutput("timer_irq", 64'(timer_irq), 64'(mIrq));
      checkOutput("uart_overflow", 64'(uart_overflow), 64'(mOvf));
    end
  end

  function automatic logic [63:0] pickAddr();
    logic [63:0] a;
    case ($urandom_range(0, 10))
      0, 1, 2, 3: a = RAM_BASE + 64'($urandom_range(0, 15)) * 64'd8;
      4:       a = RAM_LAST;
      5:       a = RAM_END;
      6:       a = RAM_BASE - 64'd8;
      7:       a = CMP_A;
      8:       a = MTIME_A;
      9:       a = UART_BASE;
      default: a = 64'h3000_0000;
    endcase
    return a | 64'($urandom_range(0, 7));
  endfunction

  initial begin
    int n;
    logic [63:0] v;
    rst = 1; inst_addr = 0; inst_ena = 0; mem_raddr = 0; mem_rena = 0;
    mem_waddr = 0; mem_wdata = 0; mem_wmask = 0; mem_wena = 0; uart_tx_ready = 0;
    for (int i = 0; i < 16; i++) begin
      v = {$urandom, $urandom};
      if (i == 0) v = 64'h1122334455667788;
      if (i == 1) v = 64'hCAFEBABE_DEADBEEF;
      dut.r_ram[i] = v;
      mRam[i] = v;
    end
    dut.r_ram[RAM_WORDS-1] = 64'h0123456789ABCDEF;
    mRam[RAM_WORDS-1] = 64'h0123456789ABCDEF;

    applyStimulus();
    chkEn = 1;
    #1 checkOutput("reset_valid", 64'(uart_tx_valid), 64'h0);
    checkOutput("reset_data", 64'(uart_tx_data), 64'h0);
    checkOutput("reset_irq", 64'(timer_irq), 64'h0);
    checkOutput("reset_ovf", 64'(uart_overflow), 64'h0);
    applyStimulus();
    rst = 0;

    // Byte store with same-cycle read returning the old word.
    mem_wena = 1; mem_waddr = 64'h8000_0001; mem_wdata = 64'hAB00; mem_wmask = 64'hFF00;
    mem_rena = 1; mem_raddr = 64'h8000_0000;
    #1 checkOutput("ram_old", mem_rdata, 64'h1122334455667788);
    applyStimulus();
    mem_wena = 0;
    #1 checkOutput("ram_new", mem_rdata, 64'h112233445566AB88);

    inst_ena = 1; inst_addr = 64'h8000_0004; mem_raddr = 64'h8000_0008;
    #1 checkOutput("dual_inst", inst_rdata, 64'h112233445566AB88);
    checkOutput("dual_data", mem_rdata, 64'hCAFEBABE_DEADBEEF);
    mem_raddr = 64'h3000_0000;
    #1 checkOutput("unmapped", mem_rdata, 64'h0);
    mem_raddr = RAM_LAST; inst_addr = RAM_END;
    #1 checkOutput("ram_last", mem_rdata, 64'h0123456789ABCDEF);
    checkOutput("ram_end", inst_rdata, 64'h0);
    mem_raddr = 64'h8000_0000; mem_rena = 0; inst_addr = MTIME_A;
    #1 checkOutput("rena_low", mem_rdata, 64'h0);
    checkOutput("fetch_mmio", inst_rdata, 64'h0);
    inst_ena = 0;
    applyStimulus();

    // Timer: irq follows mtime reaching mtimecmp by one cycle.
    rst = 1;
    applyStimulus();
    rst = 0;
    mem_wena = 1; mem_waddr = CMP_A; mem_wdata = 64'd10; mem_wmask = '1;
    applyStimulus();
    mem_wena = 0; mem_rena = 1; mem_raddr = MTIME_A;
    n = 0;
    #1;
    while (n < 20 && mem_rdata != 64'd10) begin
      applyStimulus();
      n++;
      #1;
    end
    checkOutput("mtime_reach_cycles", 64'(n), 64'd9);
    checkOutput("irq_before", 64'(timer_irq), 64'h0);
    applyStimulus();
    #1 checkOutput("irq_rise", 64'(timer_irq), 64'h1);
    mem_wena = 1; mem_waddr = CMP_A; mem_wdata = '1; mem_wmask = '1;
    applyStimulus();
    mem_wena = 0;
    #1 checkOutput("irq_hold", 64'(timer_irq), 64'h1);
    applyStimulus();
    #1 checkOutput("irq_drop", 64'(timer_irq), 64'h0);

    // UART fill, overflow and drain.
    rst = 1;
    applyStimulus();
    rst = 0; uart_tx_ready = 0;
    for (int i = 0; i < 8; i++) begin
      mem_wena = 1; mem_waddr = UART_BASE; mem_wdata = 64'(8'h41 + i); mem_wmask = 64'hFF;
      applyStimulus();
    end
    mem_wena = 0; mem_rena = 1; mem_raddr = UART_BASE;
    #1 checkOutput("lsr_full", mem_rdata, 64'h0);
    mem_wena = 1; mem_wdata = 64'h49;
    applyStimulus();
    mem_wena = 0;
    #1 checkOutput("overflow_set", 64'(uart_overflow), 64'h1);
    uart_tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1 checkOutput("drain_valid", 64'(uart_tx_valid), 64'h1);
      checkOutput("drain_byte", 64'(uart_tx_data), 64'(8'h41 + i));
      applyStimulus();
    end
    #1 checkOutput("drain_empty", 64'(uart_tx_valid), 64'h0);
    checkOutput("lsr_empty", mem_rdata, 64'h0000_6000_0000_0000);
    uart_tx_ready = 0;

    // Reset in the middle of activity.
    for (int i = 0; i < 3; i++) begin
      mem_wena = 1; mem_waddr = UART_BASE; mem_wdata = 64'(8'h61 + i); mem_wmask = 64'hFF;
      applyStimulus();
    end
    mem_waddr = MTIME_A; mem_wdata = 64'd500; mem_wmask = '1;
    applyStimulus();
    mem_wena = 0; mem_raddr = MTIME_A;
    #1 checkOutput("pre_rst_mtime", mem_rdata, 64'd500);
    checkOutput("pre_rst_valid", 64'(uart_tx_valid), 64'h1);
    rst = 1;
    applyStimulus();
    rst = 0;
    #1 checkOutput("rst_valid", 64'(uart_tx_valid), 64'h0);
    checkOutput("rst_mtime", mem_rdata, 64'h0);
    checkOutput("rst_irq", 64'(timer_irq), 64'h0);
    checkOutput("rst_ovf", 64'(uart_overflow), 64'h0);
    mem_raddr = RAM_BASE;
    #1 checkOutput("rst_ram", mem_rdata, 64'h112233445566AB88);

    // Full FIFO accepting a push and a pop together.
    for (int i = 0; i < 8; i++) begin
      mem_wena = 1; mem_waddr = UART_BASE; mem_wdata = 64'(8'h10 + i); mem_wmask = 64'hFF;
      applyStimulus();
    end
    mem_wdata = 64'h18; uart_tx_ready = 1;
    #1 checkOutput("pp_head", 64'(uart_tx_data), 64'h10);
    applyStimulus();
    mem_wena = 0; uart_tx_ready = 0; mem_raddr = UART_BASE;
    #1 checkOutput("pp_ovf", 64'(uart_overflow), 64'h0);
    checkOutput("pp_still_full", mem_rdata, 64'h0);
    checkOutput("pp_next", 64'(uart_tx_data), 64'h11);
    uart_tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1 checkOutput("pp_drain", 64'(uart_tx_data), 64'(8'h11 + i));
      applyStimulus();
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      inst_ena = $urandom_range(0, 1);
      inst_addr = pickAddr();
      mem_rena = ($urandom_range(0, 3) != 0);
      mem_raddr = pickAddr();
      mem_wena = !rst && ($urandom_range(0, 1) == 1);
      mem_waddr = pickAddr();
      mem_wdata = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) mem_wdata = 64'($urandom_range(0, 2000));
      for (int b = 0; b < 8; b++) mem_wmask[b*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      uart_tx_ready = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end

    chkEn = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
